// File: rtl/mdu_pkg.sv
// Shared opcode/state types and decode helpers for the
// iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_MADD  = 4'd2,
        OP_MADDU = 4'd3,
        OP_MSUB  = 4'd4,
        OP_MSUBU = 4'd5,
        OP_DIV   = 4'd6,
        OP_DIVU  = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9,
        OP_NOP   = 4'd15
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

    function automatic logic is_multicycle(input mdu_op_t op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
                          OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed_op(input mdu_op_t op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
    endfunction

    function automatic logic is_macc_add(input mdu_op_t op);
        return op inside {OP_MADD, OP_MADDU};
    endfunction

    function automatic logic is_macc_sub(input mdu_op_t op);
        return op inside {OP_MSUB, OP_MSUBU};
    endfunction

endpackage

// File: rtl/mdu_div_radix2.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle,
// WIDTH cycles after start, then a one-cycle valid pulse.
module mdu_div_radix2
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] den;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Top bit of diff set means the trial subtraction borrowed.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, den};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy  <= 1'b0;
            valid <= 1'b0;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            den   <= '0;
        end else begin
            valid <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else if (start) begin
                busy <= 1'b1;
                cnt  <= '0;
                rem  <= '0;
                quo  <= dividend;
                den  <= divisor;
            end else if (busy) begin
                if (diff[WIDTH]) begin
                    rem <= shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end else begin
                    rem <= diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end
                cnt <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/mdu_iter.sv
// Multicycle multiply/divide unit with HI/LO storage and a
// commit-once DONE state for stalled EXE stages.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_STAGES  = 3,
    parameter bit ENABLE_MACC = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic             issue_hold,
    input  logic [3:0]       issue_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2  = 2 * WIDTH;
    localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    mdu_state_t       state;
    mdu_state_t       state_nx;
    mdu_op_t          op_in;
    mdu_op_t          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             zero_q;
    logic             neg_q;
    logic             neg_r;
    logic [MCW-1:0]   mul_cnt;
    logic             mul_last;
    logic             accept;
    logic             mt_write;
    logic             commit;
    logic             done_q;
    logic             sgn_in;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             div_start;
    logic             div_valid;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [W2-1:0]    ext_a;
    logic [W2-1:0]    ext_b;
    logic [W2-1:0]    prod_comb;
    logic [W2-1:0]    prod_fin;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    div_res;
    logic [W2-1:0]    res;

    assign op_in    = mdu_op_t'(issue_op);
    assign accept   = (state == S_IDLE) && issue_valid && !flush
                      && is_multicycle(op_in);
    assign mt_write = (state == S_IDLE) && issue_valid && !issue_hold
                      && !flush && (op_in inside {OP_MTHI, OP_MTLO});
    assign mul_last = (mul_cnt == MCW'(MUL_STAGES - 1));

    assign sgn_in    = is_signed_op(op_in);
    assign mag_a     = (sgn_in && src_a[WIDTH-1]) ? -src_a : src_a;
    assign mag_b     = (sgn_in && src_b[WIDTH-1]) ? -src_b : src_b;
    assign div_start = accept && is_div(op_in) && (src_b != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = is_div(op_in) ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                if (mul_last) state_nx = S_DONE;
            end
            S_DIV: begin
                if (zero_q || div_valid) state_nx = S_DONE;
            end
            S_DONE: begin
                if (!issue_hold) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_comb begin
        stall = issue_valid && is_multicycle(op_in) && (state != S_DONE);
        done  = done_q;
    end

    // A flush redirects state_nx, so it also cancels the commit.
    assign commit = (state != S_DONE) && (state_nx == S_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            mul_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= commit;
            if (accept) begin
                op_q    <= op_in;
                a_q     <= src_a;
                b_q     <= src_b;
                zero_q  <= is_div(op_in) && (src_b == '0);
                neg_q   <= sgn_in && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_r   <= sgn_in && src_a[WIDTH-1];
                mul_cnt <= '0;
            end else if (state == S_MUL) begin
                mul_cnt <= mul_cnt + 1'b1;
            end
        end
    end

    assign ext_a = is_signed_op(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q}
                                      : {{WIDTH{1'b0}}, a_q};
    assign ext_b = is_signed_op(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q}
                                      : {{WIDTH{1'b0}}, b_q};
    assign prod_comb = ext_a * ext_b;

    generate
        if (MUL_STAGES == 1) begin : g_comb
            assign prod_fin = prod_comb;
        end else begin : g_pipe
            logic [W2-1:0] pipe [MUL_STAGES-1];
            // No reset: pure data path, free to be retimed.
            always_ff @(posedge clk) begin
                pipe[0] <= prod_comb;
                for (int i = 1; i < MUL_STAGES - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
            assign prod_fin = pipe[MUL_STAGES-2];
        end
    endgenerate

    always_comb begin
        acc = prod_fin;
        if (ENABLE_MACC) begin
            unique case (1'b1)
                is_macc_add(op_q): acc = {hi, lo} + prod_fin;
                is_macc_sub(op_q): acc = {hi, lo} - prod_fin;
                default:           acc = prod_fin;
            endcase
        end
    end

    mdu_div_radix2 #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start    (div_start),
        .abort    (flush),
        .dividend (mag_a),
        .divisor  (mag_b),
        .valid    (div_valid),
        .quotient (div_q),
        .remainder(div_r)
    );

    // Magnitude MIN/-1 yields quotient MIN, which already wraps.
    assign q_fix   = neg_q ? -div_q : div_q;
    assign r_fix   = neg_r ? -div_r : div_r;
    assign div_res = zero_q ? {a_q, {WIDTH{1'b1}}} : {r_fix, q_fix};
    assign res     = (state == S_DIV) ? div_res : acc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= res[W2-1:WIDTH];
            lo <= res[WIDTH-1:0];
        end else if (mt_write) begin
            if (op_in == OP_MTHI) hi <= src_a;
            else                  lo <= src_a;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed plus random bench for mdu_iter against an
// arithmetic reference model of HI/LO and stall timing.
module tb_mdu_iter;

    localparam int W = 32;
    localparam logic [3:0] C_MULT  = 4'd0;
    localparam logic [3:0] C_MULTU = 4'd1;
    localparam logic [3:0] C_MADD  = 4'd2;
    localparam logic [3:0] C_MADDU = 4'd3;
    localparam logic [3:0] C_MSUB  = 4'd4;
    localparam logic [3:0] C_MSUBU = 4'd5;
    localparam logic [3:0] C_DIV   = 4'd6;
    localparam logic [3:0] C_DIVU  = 4'd7;
    localparam logic [3:0] C_MTHI  = 4'd8;
    localparam logic [3:0] C_MTLO  = 4'd9;
    localparam logic [3:0] C_NOP   = 4'd15;

    logic         clk = 1'b0;
    logic         resetn;
    logic         flush;
    logic         issue_valid;
    logic         issue_hold;
    logic [3:0]   issue_op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_chk = 0;
    int n_fail = 0;
    int done_total = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_total++;
    end

    mdu_iter #(
        .WIDTH(W),
        .MUL_STAGES(3),
        .ENABLE_MACC(1'b1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .issue_valid(issue_valid),
        .issue_hold (issue_hold),
        .issue_op   (issue_op),
        .src_a      (src_a),
        .src_b      (src_b),
        .stall      (stall),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result {hi,lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [63:0] hl);
        longint sp;
        longint unsigned up;
        int sq;
        int sr;
        sp = longint'(int'(a)) * longint'(int'(b));
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        case (op)
            C_MULT:  return sp;
            C_MULTU: return up;
            C_MADD:  return hl + sp;
            C_MADDU: return hl + up;
            C_MSUB:  return hl - sp;
            C_MSUBU: return hl - up;
            C_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'd0, 32'h8000_0000};
                sq = int'(a) / int'(b);
                sr = int'(a) % int'(b);
                return {sr, sq};
            end
            C_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return hl;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold,
                          input string tag);
        int sc;
        int dc;
        int exp_sc;
        bit ended;
        logic [63:0] exp;
        exp = model(op, a, b, {m_hi, m_lo});
        exp_sc = (op >= C_DIV) ? ((b == 0) ? 2 : W + 2) : 4;
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op = op;
        src_a = a;
        src_b = b;
        sc = 0;
        dc = 0;
        ended = 1'b0;
        for (int i = 0; i < 100 && !ended; i++) begin
            #1;
            if (done) dc++;
            if (!stall) ended = 1'b1;
            else begin
                sc++;
                @(negedge clk);
            end
        end
        check({tag, " finished"}, 64'(ended), 64'd1);
        issue_hold = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            if (done) dc++;
            check({tag, " stall in hold"}, 64'(stall), 64'd0);
        end
        issue_hold = 1'b0;
        @(negedge clk);
        issue_valid = 1'b0;
        issue_op = C_NOP;
        #1;
        if (done) dc++;
        check({tag, " stall cycles"}, 64'(sc), 64'(exp_sc));
        check({tag, " done pulses"}, 64'(dc), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
        check({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v,
                      input bit fl, input string tag);
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op = op;
        src_a = v;
        flush = fl;
        #1;
        check({tag, " stall"}, 64'(stall), 64'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        issue_op = C_NOP;
        flush = 1'b0;
        #1;
        if (!fl) begin
            if (op == C_MTHI) m_hi = v;
            else m_lo = v;
        end
        check({tag, " hi"}, 64'(hi), 64'(m_hi));
        check({tag, " lo"}, 64'(lo), 64'(m_lo));
    endtask

    task automatic quiet(input int cycles, input string tag);
        int d0;
        d0 = done_total;
        repeat (cycles) @(negedge clk);
        #1;
        check({tag, " no done"}, 64'(done_total - d0), 64'd0);
        check({tag, " hi kept"}, 64'(hi), 64'(m_hi));
        check({tag, " lo kept"}, 64'(lo), 64'(m_lo));
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        resetn = 1'b0;
        flush = 1'b0;
        issue_valid = 1'b0;
        issue_hold = 1'b0;
        issue_op = C_NOP;
        src_a = '0;
        src_b = '0;
        #1;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        check("reset done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run_op(C_MULT, 32'hFFFF_FFFD, 32'd5, 0, "mult -3*5");
        run_op(C_DIV, 32'd7, 32'hFFFF_FFFE, 0, "div 7/-2");
        run_op(C_DIVU, 32'd7, 32'd2, 0, "divu 7/2");

        mt(C_MTHI, 32'd1, 1'b0, "mthi 1");
        mt(C_MTLO, 32'hFFFF_FFFF, 1'b0, "mtlo ones");
        run_op(C_MADDU, 32'd1, 32'd1, 3, "maddu hold");

        mt(C_MTHI, 32'd0, 1'b0, "mthi 0");
        mt(C_MTLO, 32'd0, 1'b0, "mtlo 0");
        run_op(C_MSUB, 32'd2, 32'd3, 0, "msub 2*3");

        // Divide aborted at its tenth iteration.
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op = C_DIV;
        src_a = 32'd1000;
        src_b = 32'd3;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        issue_valid = 1'b0;
        issue_op = C_NOP;
        #1;
        check("div flush stall", 64'(stall), 64'd0);
        quiet(40, "div flush");
        run_op(C_MULT, 32'd6, 32'd7, 0, "mult 6*7");

        run_op(C_DIV, 32'h1234_5678, 32'd0, 0, "div by zero");
        mt(C_MTLO, 32'h5555_AAAA, 1'b1, "mtlo flushed");

        // Flush landing on the commit edge.
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op = C_MADD;
        src_a = 32'd9;
        src_b = 32'd9;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        issue_valid = 1'b0;
        issue_op = C_NOP;
        quiet(6, "flush at commit");

        // Flush on the issue cycle.
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op = C_DIVU;
        src_a = 32'd50;
        src_b = 32'd0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        issue_valid = 1'b0;
        issue_op = C_NOP;
        quiet(6, "flush at issue");

        run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div min/-1");
        run_op(C_MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "msubu max");

        for (int n = 0; n < 24; n++) begin
            rop = 4'($urandom_range(0, 7));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, $urandom_range(0, 2), "random");
        end

        // Reset in the middle of a multiply.
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op = C_MULTU;
        src_a = 32'd123;
        src_b = 32'd456;
        repeat (2) @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("mid reset hi", 64'(hi), 64'd0);
        check("mid reset lo", 64'(lo), 64'd0);
        check("mid reset done", 64'(done), 64'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        issue_op = C_NOP;
        resetn = 1'b1;
        m_hi = '0;
        m_lo = '0;
        quiet(5, "after reset");
        run_op(C_MULTU, 32'd123, 32'd456, 0, "mult after reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parameterised multiply/divide unit with architectural HI/LO storage. It succeeds the fixed 32-bit MULTDIV+HILO pair in the EXE stage.
- Width and multiplier depth are configurable.
- Adds MSUB/MSUBU and a defined divide-by-zero result.
- Holds a commit-once DONE state, so a MADD/MSUB never accumulates twice while EXE is frozen by an unrelated stall.
- Sits in EXE and is driven from the forwarded operands.

Parameters:
WIDTH, 32, operand and HI/LO width (even, >=8)
MUL_STAGES, 3, multiplier pipeline depth in cycles (>=1)
ENABLE_MACC, 1, 1 enables MADD/MADDU/MSUB/MSUBU; 0 treats them as MULT/MULTU

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  abort any in-flight op; no HI/LO write
issue_valid  in  1  EXE holds a valid MDU instruction
issue_hold  in  1  EXE frozen by an external stall
issue_op  in  4  mdu_op_t operation code
src_a  in  WIDTH  forwarded rs operand
src_b  in  WIDTH  forwarded rt operand
stall  out  1  freeze front end and EXE; op not yet committed
done  out  1  one-cycle pulse on HI/LO commit of a multicycle op
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, resetn=0): state=IDLE, hi=lo=0, stall=0, done=0, counters=0.
- States: IDLE, MUL, DIV, DONE.
- Multicycle ops are MULT, MULTU, MADD(U), MSUB(U), DIV and DIVU. MTHI and MTLO are single-cycle.
- stall is combinational: issue_valid && multicycle op && state!=DONE. It is asserted from the first issue cycle.
- IDLE:
  - Multicycle op with issue_valid=1 and flush=0 latches src_a, src_b and op.
  - Multiplies go to MUL. Divides go to DIV.
  - MTHI/MTLO write hi/lo at the edge when issue_valid=1, issue_hold=0 and flush=0. The write is visible on the next cycle and does not stall.
- MUL:
  - Counter runs 0..MUL_STAGES-1, then the state goes to DONE.
  - stall is high for exactly MUL_STAGES+1 cycles.
  - Product is the 2W-bit signed or unsigned product.
  - MADD: {hi,lo} + product, modulo 2^(2W). MSUB: {hi,lo} - product, modulo 2^(2W). The accumulate base is hi/lo at commit time.
- DIV:
  - First cycle takes magnitudes (signed ops) and checks src_b==0.
  - Then WIDTH restoring radix-2 iterations, one per cycle.
  - A final fix-up applies quotient sign = a^b and remainder sign = a, then the state goes to DONE. stall is high for WIDTH+2 cycles.
  - src_b==0: skip the iterations and go to DONE after the first cycle (stall 2 cycles). Result is LO = all ones, HI = src_a.
  - Signed MIN/-1: LO = MIN, HI = 0 (wrap).
- Commit: {hi,lo} is written once, on the edge entering DONE. done pulses for that single cycle.
- DONE:
  - stall=0.
  - Stays in DONE while issue_hold=1, with no re-issue and no second commit.
  - Goes to IDLE when issue_hold=0. A new op is accepted only from IDLE, i.e. the cycle after leaving DONE.
- flush:
  - Has priority over everything. The next state is IDLE.
  - The pending commit is cancelled, including when flush coincides with the entry into DONE.
  - A flush in DONE leaves the already-committed hi/lo unchanged.
  - A flush on the issue cycle starts nothing.
- Reset mid-operation: all state is lost and hi=lo=0.
- ENABLE_MACC=0: accumulate opcodes commit the plain product.

Decomposition:
- Package mdu_pkg: mdu_op_t enum, mdu_state_t enum, helper function is_multicycle(op).
  - mdu_op_t values: MULT=0, MULTU=1, MADD=2, MADDU=3, MSUB=4, MSUBU=5, DIV=6, DIVU=7, MTHI=8, MTLO=9, NOP=15.
- Sub-module mdu_div_radix2: magnitude shift/subtract iterator with a start input, WIDTH-cycle run and a valid output. The parent does the sign and zero handling.
- The multiplier is an in-module shift-register pipeline that the synthesiser retimes.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> stall high 4 cycles, done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=7, b=0xFFFFFFFE (-2) -> stall high 34 cycles, LO=0xFFFFFFFD, HI=1. DIVU a=7, b=2 -> LO=3, HI=1.
- MTHI 1, MTLO 0xFFFFFFFF, then MADDU a=1, b=1 with issue_hold=1 for 3 cycles after DONE -> HI=2, LO=0, exactly one done pulse.
- MSUB with HI=0, LO=0, a=2, b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV in flight, flush at iteration 10 -> stall low next cycle, no done, HI/LO unchanged. A following MULT 6*7 completes with LO=42.
- DIV a=0x12345678, b=0 -> stall 2 cycles, LO=0xFFFFFFFF, HI=0x12345678. Also MTLO and flush in the same cycle -> LO unchanged.
